// File: rtl/fir_dec.sv
// Decimating accumulate-and-dump, round/shift to 8 bits, small output FIFO. FIR_DEC_SAT_EN selects clamp instead of wrap.
// A result reaches o_data right after its dump edge if the FIFO was empty; on a full FIFO with no pop the result is dropped and o_ovf set.

module fir_dec_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int LW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          i_push_vld,
    input  logic [W-1:0]  i_push_dat,
    input  logic          i_pop,
    output logic [W-1:0]  o_dat,
    output logic          o_vld,
    output logic          o_full,
    output logic [LW-1:0] o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_count;
    logic          w_pop;
    logic          w_push;

    assign o_vld   = (r_count != '0);
    assign o_full  = (r_count == LW'(DEPTH));
    assign o_level = r_count;
    assign w_pop   = i_pop && o_vld;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_push  = i_push_vld && (!o_full || w_pop);
    assign o_dat   = o_vld ? r_mem[r_rptr] : '0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + LW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - LW'(1);
            end
        end
    end
endmodule

module fir_dec #(
    parameter int DEC_N = 4,
    parameter int SHIFT = 2,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_n,
    input  logic              clr,
    input  logic signed [15:0] i_data,
    input  logic              i_ready,
    output logic signed [7:0] o_data,
    output logic              o_valid,
    output logic [4:0]        o_level,
    output logic              o_ovf
);
    localparam int PW = (DEC_N > 1) ? $clog2(DEC_N) : 1;
    localparam logic signed [20:0] RND_HALF = (21'sd1 <<< SHIFT) >>> 1;

    logic signed [19:0] r_acc;
    logic [PW-1:0]      r_phase;
    logic               r_ovf;

    logic               w_en;
    logic               w_dump;
    logic signed [19:0] w_ext;
    logic signed [19:0] w_sum;
    logic signed [20:0] w_round;
    logic signed [20:0] w_shifted;
    logic [7:0]         w_res;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic [7:0]         w_head;

    assign w_en      = !en_n;
    assign w_dump    = w_en && (r_phase == PW'(DEC_N - 1));
    assign w_ext     = {{4{i_data[15]}}, i_data};
    assign w_sum     = r_acc + w_ext;
    // One guard bit so the rounding offset cannot overflow the 20-bit sum
    assign w_round   = {w_sum[19], w_sum} + RND_HALF;
    assign w_shifted = w_round >>> SHIFT;

    always_comb begin
        w_res = 8'(w_shifted);
`ifdef FIR_DEC_SAT_EN
        if (w_shifted > 21'sd127) begin
            w_res = 8'h7F;
        end else if (w_shifted < -21'sd128) begin
            w_res = 8'h80;
        end
`endif
    end

    assign w_push = w_dump && !clr;
    assign w_pop  = o_valid && i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_phase <= '0;
        end else if (clr) begin
            r_acc   <= '0;
            r_phase <= '0;
        end else if (w_en) begin
            if (w_dump) begin
                r_acc   <= '0;
                r_phase <= '0;
            end else begin
                r_acc   <= w_sum;
                r_phase <= r_phase + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (clr) begin
            r_ovf <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_ovf <= 1'b1;
        end
    end

    fir_dec_fifo #(
        .W     (8),
        .DEPTH (DEPTH),
        .LW    (5)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .i_push_vld (w_push),
        .i_push_dat (w_res),
        .i_pop      (i_ready),
        .o_dat      (w_head),
        .o_vld      (o_valid),
        .o_full     (w_full),
        .o_level    (o_level)
    );

    assign o_data = w_head;
    assign o_ovf  = r_ovf;
endmodule

// File: doc/fir_dec.md
FIR_DEC -- requirements
Module: fir_dec

Downstream stage of the 27-tap FIR. Decimates the signed 16-bit FIR output by accumulate-and-dump, scales and rounds it to 8 bits, and buffers results in a small FIFO with a valid/ready output.

Interface
REQ-001 SHALL have parameter DEC_N, default 4: decimation ratio, legal 2..16.
REQ-002 SHALL have parameter SHIFT, default 2: arithmetic right shift applied to the dump sum, legal 0..12.
REQ-003 SHALL have parameter DEPTH, default 4: FIFO entries, power of two, legal 2..16.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port en_n, input, 1 bit: active-low sample enable.
REQ-007 SHALL have port clr, input, 1 bit: synchronous clear, active-high.
REQ-008 SHALL have port i_data, input, 16 bits, signed: FIR output sample.
REQ-009 SHALL have port i_ready, input, 1 bit: consumer ready.
REQ-010 SHALL have port o_data, output, 8 bits, signed: FIFO head.
REQ-011 SHALL have port o_valid, output, 1 bit: FIFO non-empty.
REQ-012 SHALL have port o_level, output, 5 bits: FIFO occupancy, 0..DEPTH.
REQ-013 SHALL have port o_ovf, output, 1 bit: sticky overflow flag.

Function
REQ-014 SHALL, on each rising edge with en_n=0 and clr=0, add i_data into a 20-bit signed accumulator and advance the phase counter 0..DEC_N-1.
REQ-015 SHALL, on the edge where phase=DEC_N-1 (dump edge), form S = acc + i_data, clear acc to 0 and set phase to 0.
REQ-016 SHALL compute the result R = (S + 2^(SHIFT-1)) >>> SHIFT when SHIFT>0, and R = S when SHIFT=0 (round half toward +infinity).
REQ-017 SHALL, on the dump edge, write R reduced to 8 bits (see REQ-026) into the FIFO tail; the value is visible on o_data/o_valid immediately after that edge when the FIFO was empty.
REQ-018 SHALL hold the phase counter and accumulator unchanged while en_n=1; the FIFO pop side keeps operating.
REQ-019 SHALL pop the FIFO head on each edge where o_valid=1 and i_ready=1.
REQ-020 SHALL, when the FIFO is full on a dump edge with no pop, discard the new result and set o_ovf=1.
REQ-021 SHALL, when the FIFO is full on a dump edge with a pop in the same cycle, accept the push; o_level stays DEPTH and o_ovf is unchanged.
REQ-022 SHALL, when the FIFO is empty on a dump edge, ignore i_ready for that cycle (no pop).
REQ-023 SHALL give o_data first-in first-out order; read and write pointers wrap modulo DEPTH.
REQ-024 SHALL treat clr=1 as follows: clear acc, phase, FIFO pointers, o_level and o_ovf on the next edge; clr takes priority over en_n and over push/pop.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force acc=0, phase=0, FIFO empty, o_valid=0, o_level=0, o_ovf=0 and o_data=0; reset applied mid-accumulation discards the partial sum.

Configuration
REQ-026 SHALL use macro FIR_DEC_SAT_EN: when defined, clamp R to [-128, 127] before the FIFO write; when undefined, write R[7:0] (two's-complement wrap).

Verification (DEC_N=4, SHIFT=2, DEPTH=4 unless stated)
REQ-027 SHALL cover: i_data=100 for 4 enabled cycles -> S=400, o_data=100, o_valid=1 after the 4th edge, o_level=1.
REQ-028 SHALL cover: i_data=-3 x4 -> S=-12, o_data=-3; i_data=1000 x4 -> o_data=127 with FIR_DEC_SAT_EN defined, -24 (0xE8) without it.
REQ-029 SHALL cover: i_ready=0 and 5 dumps -> o_level=4, o_ovf=1, and drain order equals the first 4 results; with a pop on the 5th dump edge -> o_ovf=0 and the 5th result is retained.
REQ-030 SHALL cover: en_n=1 for 3 cycles between samples 2 and 3 -> result identical to uninterrupted input, delayed by 3 cycles.
REQ-031 SHALL cover: clr=1 after 2 samples, or rst_n=0 mid-accumulation -> o_valid=0 and o_level=0; the next 4 samples produce a fresh result with no residue.
